// File: rtl/gpr_fwd_scoreboard.sv
// GPR operand forwarding with a long-latency (mul/div) write scoreboard.
// Each read port picks its operand from the youngest matching pipeline
// stage, then from a completing long op, else from the register file,
// and raises stall when the operand it needs has not been produced yet.
module gpr_fwd_scoreboard #(
    parameter int NUM_PORTS  = 2,
    parameter int NUM_STAGES = 3,
    parameter int LOP_DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [32*NUM_PORTS-1:0] regFile,
    input  logic [5*NUM_PORTS-1:0]  regRequest,
    input  logic [NUM_PORTS-1:0]    EN,
    input  logic [5*NUM_STAGES-1:0] stage_wb,
    input  logic [NUM_STAGES-1:0]   stage_dv,
    input  logic [32*NUM_STAGES-1:0] stage_data,
    input  logic                    lop_start,
    input  logic [4:0]              lop_wb,
    input  logic                    lop_done,
    input  logic [31:0]             lop_data,
    output logic [32*NUM_PORTS-1:0] dataOut,
    output logic                    stall,
    output logic                    lop_full,
    output logic                    lop_err
);

    localparam int PTR_W = $clog2(LOP_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(LOP_DEPTH);

    logic [4:0]           lop_q_reg [LOP_DEPTH];
    logic [PTR_W-1:0]     rd_ptr_reg;
    logic [PTR_W-1:0]     wr_ptr_reg;
    logic [CNT_W-1:0]     count_reg;
    logic [CNT_W-1:0]     count_next;
    logic                 err_reg;

    logic                 q_full;
    logic                 q_empty;
    logic                 push;
    logic                 pop;
    logic                 err_set;
    logic [LOP_DEPTH-1:0] slot_valid;
    logic [LOP_DEPTH-1:0] head_onehot;
    logic [NUM_PORTS-1:0] port_stall;

    assign q_full  = (count_reg == DEPTH_CNT);
    assign q_empty = (count_reg == '0);

    // A pop at full frees the slot for a same-cycle push; a done with an
    // empty queue is never a pop, even when a push arrives with it.
    assign push    = lop_start && (!q_full || lop_done);
    assign pop     = lop_done && !q_empty;
    assign err_set = (lop_start && q_full && !lop_done) ||
                     (lop_done && q_empty && !lop_start);

    assign count_next  = count_reg + CNT_W'(push) - CNT_W'(pop);
    assign head_onehot = {{(LOP_DEPTH-1){1'b0}}, 1'b1} << rd_ptr_reg;

    assign lop_full = q_full;
    assign lop_err  = err_reg;
    assign stall    = |port_stall;

    // Scoreboard pointers, occupancy and sticky protocol error.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            err_reg    <= 1'b0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            count_reg <= count_next;
            if (err_set) err_reg <= 1'b1;
        end
    end

    // Destination storage; stale slots are masked by slot_valid, so no reset.
    always_ff @(posedge clk) begin
        if (!rst && push) lop_q_reg[wr_ptr_reg] <= lop_wb;
    end

    // A slot is live when its distance from the head is below the count.
    for (genvar gi = 0; gi < LOP_DEPTH; gi++) begin : g_slot
        logic [PTR_W-1:0] slot_off;
        assign slot_off       = PTR_W'(gi) - rd_ptr_reg;
        assign slot_valid[gi] = ({1'b0, slot_off} < count_reg);
    end

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
        logic [4:0]           req;
        logic [31:0]          rf_data;
        logic                 active;
        logic                 stg_hit;
        logic                 stg_dv;
        logic [31:0]          stg_data;
        logic [LOP_DEPTH-1:0] lop_match;
        logic [31:0]          port_data;
        logic                 port_stall_c;

        assign req     = regRequest[5*gi +: 5];
        assign rf_data = regFile[32*gi +: 32];
        assign active  = EN[gi] && (req != 5'd0) && !rst;

        // Youngest matching stage wins: scan oldest-first so lower index overwrites.
        always_comb begin
            stg_hit  = 1'b0;
            stg_dv   = 1'b0;
            stg_data = '0;
            for (int s = NUM_STAGES - 1; s >= 0; s--) begin
                if (stage_wb[5*s +: 5] == req) begin
                    stg_hit  = 1'b1;
                    stg_dv   = stage_dv[s];
                    stg_data = stage_data[32*s +: 32];
                end
            end
        end

        // Live scoreboard slots holding this port's register.
        always_comb begin
            lop_match = '0;
            for (int i = 0; i < LOP_DEPTH; i++) begin
                lop_match[i] = slot_valid[i] && (lop_q_reg[i] == req);
            end
        end

        // Operand select: pipeline first, then long op, else register file.
        always_comb begin
            port_data    = rf_data;
            port_stall_c = 1'b0;
            if (active) begin
                if (stg_hit) begin
                    if (stg_dv) port_data = stg_data;
                    else        port_stall_c = 1'b1;
                end else if (lop_match != '0) begin
                    if (lop_match == head_onehot && lop_done) port_data = lop_data;
                    else                                      port_stall_c = 1'b1;
                end
            end
        end

        assign dataOut[32*gi +: 32] = port_data;
        assign port_stall[gi]       = port_stall_c;
    end

endmodule

// File: doc/gpr_fwd_scoreboard.md
GPR_FWD_SCOREBOARD -- requirements
Module: gpr_fwd_scoreboard

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2: number of independent GPR read ports.
REQ-002 SHALL have parameter NUM_STAGES, default 3: number of in-pipeline forwarding stages; stage 0 is the youngest.
REQ-003 SHALL have parameter LOP_DEPTH, default 4, power of two >= 2: maximum number of outstanding long-latency (mul/div) writes.
REQ-004 SHALL have one clock; reset is synchronous and active-high:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
REQ-005 SHALL have the following ports:
- regFile  in  32*NUM_PORTS  register-file read data, port p at bits [32p+31:32p]
- regRequest  in  5*NUM_PORTS  requested GPR number per port
- EN  in  NUM_PORTS  per-port read enable
- stage_wb  in  5*NUM_STAGES  destination GPR of each pipeline stage (0 = no write)
- stage_dv  in  NUM_STAGES  stage result valid this cycle
- stage_data  in  32*NUM_STAGES  stage result data
- lop_start  in  1  long op issued this cycle
- lop_wb  in  5  destination GPR of the issued long op
- lop_done  in  1  oldest outstanding long op completes this cycle
- lop_data  in  32  result of the completing long op
- dataOut  out  32*NUM_PORTS  forwarded operand per port
- stall  out  1  operand not yet available on any port
- lop_full  out  1  scoreboard holds LOP_DEPTH entries
- lop_err  out  1  sticky protocol-error flag

Function
REQ-006 SHALL evaluate each port independently and combinationally; stall SHALL be the OR of all per-port stalls.
REQ-007 A port SHALL be inactive when EN=0 or regRequest=0; an inactive port SHALL output regFile and contribute no stall.
REQ-008 For an active port, the matching pipeline stage SHALL be the lowest-index stage s with stage_wb[s]=regRequest.
REQ-009 If a matching stage exists: with stage_dv[s]=1 the port SHALL output stage_data[s]; with stage_dv[s]=0 it SHALL assert stall and output regFile.
REQ-010 Pipeline matches SHALL take priority over the long-op scoreboard.
REQ-011 The scoreboard SHALL be an in-order FIFO of LOP_DEPTH 5-bit destinations with a count register of width log2(LOP_DEPTH)+1.
REQ-012 On an active port with no pipeline match, and a valid scoreboard entry matching regRequest:
- SHALL forward lop_data with no stall when the only matching entry is the head and lop_done=1;
- otherwise SHALL assert stall.
REQ-013 With no pipeline or scoreboard match, an active port SHALL output regFile.
REQ-014 lop_start when count<LOP_DEPTH SHALL push lop_wb at the next edge; lop_wb=0 SHALL occupy a slot but never match.
REQ-015 lop_done when count>0 SHALL pop the head at the next edge.
REQ-016 Simultaneous lop_start and lop_done with 0<count<LOP_DEPTH SHALL push and pop in the same edge, leaving count unchanged.
REQ-017 Simultaneous lop_start and lop_done at count=LOP_DEPTH SHALL be accepted; the pop frees the slot.
REQ-018 Simultaneous lop_start and lop_done at count=0: the push SHALL be accepted and the done SHALL be ignored.
REQ-019 lop_start at full without lop_done SHALL be dropped and set lop_err.
REQ-020 lop_done at count=0 SHALL be ignored and set lop_err.
REQ-021 lop_err SHALL remain set until reset.
REQ-022 lop_full SHALL be registered-equivalent (count==LOP_DEPTH) and SHALL NOT depend combinationally on lop_start.
REQ-023 Read and write pointers SHALL wrap modulo LOP_DEPTH.
REQ-024 Latency: forwarding SHALL be 0 cycles (combinational); a pushed entry SHALL be visible to matching from the cycle after lop_start.

Reset
REQ-025 When rst=1 at a rising edge: count=0, both pointers=0, lop_err=0, lop_full=0; a lop_start/lop_done in that cycle SHALL be discarded.
REQ-026 Reset mid-operation SHALL discard all outstanding entries, so no scoreboard stall follows reset.
REQ-027 While rst=1, stall SHALL be 0 and dataOut SHALL equal regFile.

Verification
REQ-028 Port0 req=5, stage_wb={5,5,0}, stage_dv={0,1,0} -> stall=1, dataOut0=regFile0; then dv0=1, stage_data0=0xAAAA0000 -> stall=0, dataOut0=0xAAAA0000.
REQ-029 Port0 req=0, stage_wb0=0, dv0=1 -> dataOut0=regFile0, stall=0; same with EN0=0 and req=7 matching -> no forward.
REQ-030 lop_start wb=9, then port1 req=9 -> stall=1 each cycle; lop_done, lop_data=0x12345678 -> stall=0, dataOut1=0x12345678; next cycle -> dataOut1=regFile1.
REQ-031 Four lop_starts -> lop_full=1; fifth start alone -> dropped, lop_err=1; start+done together at full -> count stays 4, lop_full=1.
REQ-032 lop_done at empty -> lop_err=1, count=0; rst pulse -> lop_err=0.
REQ-033 Pending wb=3 (head) and wb=3 (second), lop_done -> stall remains 1; after the second done -> no stall; reset with 3 entries -> stall=0 on req=3 next cycle.
